map_latch_gen: RTL and testbench
================================

# map_latch_gen

Parametrised discrete-logic address-latch mapper core for NES multicart images. It generalises the single-register "write address to $8000-$FFFF" latch mapper in three ways: bank widths are set by parameter, a lockable outer-bank register sits at $6000-$7FFF, and a CPU-cycle IRQ counter is optional. The block sits between the CPU/PPU bus decode and the PRG/CHR memory address outputs, in place of a fixed per-mapper module.

## Interface
- PRG_BW, 4: inner PRG 16 KB bank bits (1..5)
- CHR_BW, 4: inner CHR 8 KB bank bits (1..6)
- OUTER_BW, 2: outer bank bits (0..7), prepended to both PRG and CHR bank
- m2  in  1  CPU M2 clock; all state updates on falling edge
- map_rst_n  in  1  asynchronous, active-low reset
- cpu_addr  in  16  CPU address
- cpu_dat  in  8  CPU write data
- cpu_rw  in  1  1 = read, 0 = write
- ppu_addr  in  14  PPU address
- ss_act  in  1  save-state access active
- ss_we  in  1  save-state write strobe
- ss_addr  in  8  save-state register index
- ss_rdat  out  8  save-state read data
- prg_addr  out  OUTER_BW+PRG_BW+14  PRG ROM address
- chr_addr  out  OUTER_BW+CHR_BW+13  CHR address
- ciram_a10  out  1  nametable select
- irq  out  1  active-high IRQ request (constant 0 without the macro)

## Operation
- Inner latch, on a write to $8000-$FFFF: chr ← cpu_addr[CHR_BW-1:0], mir ← cpu_addr[6], prg_mode ← cpu_addr[7], prg ← cpu_addr[8 +: PRG_BW]. cpu_dat is ignored.
- Outer register, on a write to $6000-$7FFF while lock=0: outer ← cpu_dat[OUTER_BW-1:0], lock ← cpu_dat[7]. While lock=1 the write is ignored. Only reset clears lock.
- prg_addr[13:0] = cpu_addr[13:0].
- prg_mode=0: upper bits = {outer, prg}, so the 16 KB bank is mirrored at $8000 and $C000.
- prg_mode=1: upper bits = {outer, prg[PRG_BW-1:1], cpu_addr[14]}, selecting a 32 KB bank.
- chr_addr = {outer, chr, ppu_addr[12:0]}.
- ciram_a10 = mir ? ppu_addr[11] : ppu_addr[10].
- Save-state indexes (all other indexes read 8'hFF; unused bits read 0):
  - 0: {prg_mode, mir, chr}
  - 1: prg
  - 2: {lock, outer}
  - 3/4: counter lo/hi
  - 5/6: reload lo/hi
  - 7: {irq, en}
- When ss_act=1, only save-state writes (ss_we) modify state. Bus writes are ignored and the IRQ counter is frozen.
- Reset values: every register is 0 and irq=0. The output addresses are therefore {0…, cpu_addr[13:0]} and {0…, ppu_addr[12:0]}.

## Timing
- Register writes take effect on the falling edge of m2 in the write cycle. Outputs are combinational from the registers, so the new mapping applies from the next CPU cycle.
- Asserting map_rst_n low clears all state immediately, mid-cycle included. The first edge after release behaves normally.
- IRQ counter (macro on): 16-bit down-counter, decremented on each m2 falling edge while en=1.
  - At counter==0 with en=1: irq←1 and counter←reload on the same edge.
  - The counter wraps to reload, never to 0xFFFF.
- IRQ registers:
  - $5000 write: reload[7:0].
  - $5001 write: reload[15:8].
  - $5002 write: en←cpu_dat[0] and irq←0 (acknowledge). If cpu_dat[0]=1, counter←reload.
- Simultaneous events:
  - Expiry and a $5002 acknowledge on the same edge: the acknowledge wins (irq=0) and the counter loads from reload.
  - A reload write on the same edge as expiry: the counter loads the old reload value, and the new value is used next time.
- en=0 holds the counter value. irq stays asserted until it is acknowledged or the block is reset.

## Configuration
- MAP_LATCH_IRQ_EN defined: the IRQ counter, the $5000-$5002 registers and save-state indexes 3-7 are present.
- MAP_LATCH_IRQ_EN undefined: none of that logic is built, irq is tied to 0, indexes 3-7 read 8'hFF, and $5000-$5FFF writes are ignored.

## Test plan
- Latch write and mirroring:
  - Reset, then write to $8000|0x0145 (PRG_BW=4, CHR_BW=4) → chr=5, mir=1, prg_mode=0, prg=1.
  - Read at $C123 → prg_addr = 0x04123.
  - ciram_a10 follows ppu_addr[11].
- 32 KB mode: write $8000|0x0380, then read $C000 → prg_addr[17:14] = 0b0011. Read $8000 → 0b0010.
- Outer lock:
  - Write 0x82 to $6000 → outer=2, lock=1, prg_addr[19:18]=2.
  - Write 0x01 to $6000 → outer stays 2.
  - Pulse map_rst_n → outer=0, lock=0.
- IRQ (macro on):
  - Write 0x03 to $5000, 0x00 to $5001, 0x01 to $5002 → irq rises on the 4th falling edge after the $5002 write, and the counter reads back 3.
  - Write 0x00 to $5002 → irq=0 and the counter halts.
- Save-state:
  - With ss_act=1, write 0x40 at index 0 while the bus writes $8000 → mir=1, chr=0, and the bus write is ignored.
  - Index 9 reads 0xFF.
- Macro off: irq stays 0 for 70000 cycles after a $5002 write of 0x01.

Source files
------------

// File: rtl/map_latch_gen.sv
// Parametrised NES address-latch mapper: inner PRG/CHR latch, lockable outer bank, save-state port.
// Optional CPU-cycle IRQ counter is built only when MAP_LATCH_IRQ_EN is defined.
module map_latch_gen #(
   parameter int PRG_BW   = 4,
   parameter int CHR_BW   = 4,
   parameter int OUTER_BW = 2
) (
   input  logic                         m2,
   input  logic                         map_rst_n,
   input  logic [15:0]                  cpu_addr,
   input  logic [7:0]                   cpu_dat,
   input  logic                         cpu_rw,
   input  logic [13:0]                  ppu_addr,
   input  logic                         ss_act,
   input  logic                         ss_we,
   input  logic [7:0]                   ss_addr,
   output logic [7:0]                   ss_rdat,
   output logic [OUTER_BW+PRG_BW+13:0]  prg_addr,
   output logic [OUTER_BW+CHR_BW+12:0]  chr_addr,
   output logic                         ciram_a10,
   output logic                         irq
);

   localparam int OW1 = (OUTER_BW > 0) ? OUTER_BW : 1;

   logic [CHR_BW-1:0] r_chr;
   logic [PRG_BW-1:0] r_prg;
   logic              r_mir;
   logic              r_prg_mode;
   logic [OW1-1:0]    r_outer;
   logic              r_lock;

   logic              w_bus_wr;
   logic              w_ss_wr;
   logic [PRG_BW-1:0] w_prg_bank;
   logic              w_unused_bits;

   assign w_bus_wr      = !cpu_rw && !ss_act;
   assign w_ss_wr       = ss_act && ss_we;
   assign w_unused_bits = ^{cpu_dat, ppu_addr[13], r_outer};

   always_ff @(negedge m2 or negedge map_rst_n) begin
      if (!map_rst_n) begin
         r_chr      <= '0;
         r_prg      <= '0;
         r_mir      <= 1'b0;
         r_prg_mode <= 1'b0;
         r_outer    <= '0;
         r_lock     <= 1'b0;
      end else if (w_ss_wr) begin
         case (ss_addr)
            8'd0: begin
               r_prg_mode <= cpu_dat[7];
               r_mir      <= cpu_dat[6];
               r_chr      <= cpu_dat[CHR_BW-1:0];
            end
            8'd1: r_prg <= cpu_dat[PRG_BW-1:0];
            8'd2: begin
               r_lock <= cpu_dat[7];
               if (OUTER_BW > 0) r_outer <= cpu_dat[OW1-1:0];
            end
            default: ;
         endcase
      end else if (w_bus_wr) begin
         if (cpu_addr[15]) begin
            r_chr      <= cpu_addr[CHR_BW-1:0];
            r_mir      <= cpu_addr[6];
            r_prg_mode <= cpu_addr[7];
            r_prg      <= cpu_addr[8 +: PRG_BW];
         end else if (cpu_addr[15:13] == 3'b011 && !r_lock) begin
            r_lock <= cpu_dat[7];
            if (OUTER_BW > 0) r_outer <= cpu_dat[OW1-1:0];
         end
      end
   end

   // 32 KB mode replaces the bank LSB with A14 so both halves come from one even/odd pair.
   always_comb begin
      w_prg_bank = r_prg;
      if (r_prg_mode) w_prg_bank[0] = cpu_addr[14];
   end

   generate
      if (OUTER_BW > 0) begin : g_outer
         assign prg_addr = {r_outer, w_prg_bank, cpu_addr[13:0]};
         assign chr_addr = {r_outer, r_chr, ppu_addr[12:0]};
      end else begin : g_no_outer
         assign prg_addr = {w_prg_bank, cpu_addr[13:0]};
         assign chr_addr = {r_chr, ppu_addr[12:0]};
      end
   endgenerate

   assign ciram_a10 = r_mir ? ppu_addr[11] : ppu_addr[10];

`ifdef MAP_LATCH_IRQ_EN
   logic [15:0] r_cnt;
   logic [15:0] r_reload;
   logic        r_en;
   logic        r_irq;

   // Expiry is evaluated before the register writes so a $5002 ack overrides it,
   // and a same-edge reload write only affects the next wrap.
   always_ff @(negedge m2 or negedge map_rst_n) begin
      if (!map_rst_n) begin
         r_cnt    <= '0;
         r_reload <= '0;
         r_en     <= 1'b0;
         r_irq    <= 1'b0;
      end else if (ss_act) begin
         if (ss_we) begin
            case (ss_addr)
               8'd3: r_cnt[7:0]     <= cpu_dat;
               8'd4: r_cnt[15:8]    <= cpu_dat;
               8'd5: r_reload[7:0]  <= cpu_dat;
               8'd6: r_reload[15:8] <= cpu_dat;
               8'd7: begin
                  r_irq <= cpu_dat[1];
                  r_en  <= cpu_dat[0];
               end
               default: ;
            endcase
         end
      end else begin
         if (r_en) begin
            if (r_cnt == 16'd0) begin
               r_irq <= 1'b1;
               r_cnt <= r_reload;
            end else begin
               r_cnt <= r_cnt - 16'd1;
            end
         end
         if (!cpu_rw) begin
            case (cpu_addr)
               16'h5000: r_reload[7:0]  <= cpu_dat;
               16'h5001: r_reload[15:8] <= cpu_dat;
               16'h5002: begin
                  r_en  <= cpu_dat[0];
                  r_irq <= 1'b0;
                  if (cpu_dat[0]) r_cnt <= r_reload;
               end
               default: ;
            endcase
         end
      end
   end

   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      ss_rdat = 8'hFF;
      case (ss_addr)
         8'd0: begin
            ss_rdat               = '0;
            ss_rdat[7]            = r_prg_mode;
            ss_rdat[6]            = r_mir;
            ss_rdat[CHR_BW-1:0]   = r_chr;
         end
         8'd1: begin
            ss_rdat               = '0;
            ss_rdat[PRG_BW-1:0]   = r_prg;
         end
         8'd2: begin
            ss_rdat               = '0;
            ss_rdat[7]            = r_lock;
            if (OUTER_BW > 0) ss_rdat[OW1-1:0] = r_outer;
         end
`ifdef MAP_LATCH_IRQ_EN
         8'd3: ss_rdat = r_cnt[7:0];
         8'd4: ss_rdat = r_cnt[15:8];
         8'd5: ss_rdat = r_reload[7:0];
         8'd6: ss_rdat = r_reload[15:8];
         8'd7: ss_rdat = {6'd0, r_irq, r_en};
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_map_latch_gen.sv
// Self-checking bench for map_latch_gen: directed steps plus randomized bus/save-state traffic
// checked against a field-level behavioural model of the mapper.
module tb_map_latch_gen;

   localparam int PRG_BW   = 4;
   localparam int CHR_BW   = 4;
   localparam int OUTER_BW = 2;

   logic        m2;
   logic        rst_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dat;
   logic        cpu_rw;
   logic [13:0] ppu_addr;
   logic        ss_act;
   logic        ss_we;
   logic [7:0]  ss_addr;
   logic [7:0]  ss_rdat;
   logic [OUTER_BW+PRG_BW+13:0] prg_addr;
   logic [OUTER_BW+CHR_BW+12:0] chr_addr;
   logic        ciram_a10;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   map_latch_gen #(.PRG_BW(PRG_BW), .CHR_BW(CHR_BW), .OUTER_BW(OUTER_BW)) dut (
      .m2(m2), .map_rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_rw(cpu_rw),
      .ppu_addr(ppu_addr), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_rdat(ss_rdat),
      .prg_addr(prg_addr), .chr_addr(chr_addr), .ciram_a10(ciram_a10), .irq(irq)
   );

   initial begin
      m2 = 1'b1;
      forever #5 m2 = ~m2;
   end

   // Behavioural model: mapper fields as plain integers.
   int m_chr = 0, m_prg = 0, m_mir = 0, m_mode = 0, m_outer = 0, m_lock = 0;
   int m_cnt = 0, m_rel = 0, m_en = 0, m_irq = 0;

   task automatic model_reset();
      m_chr = 0; m_prg = 0; m_mir = 0; m_mode = 0; m_outer = 0; m_lock = 0;
      m_cnt = 0; m_rel = 0; m_en = 0; m_irq = 0;
   endtask

   task automatic model_edge();
      int a = int'(cpu_addr);
      int d = int'(cpu_dat);
      if (ss_act) begin
         if (ss_we) begin
            case (int'(ss_addr))
               0: begin m_mode = (d >> 7) & 1; m_mir = (d >> 6) & 1; m_chr = d % (1 << CHR_BW); end
               1: m_prg = d % (1 << PRG_BW);
               2: begin m_lock = (d >> 7) & 1; m_outer = d % (1 << OUTER_BW); end
`ifdef MAP_LATCH_IRQ_EN
               3: m_cnt = (m_cnt & 'hFF00) | d;
               4: m_cnt = (m_cnt & 'h00FF) | (d << 8);
               5: m_rel = (m_rel & 'hFF00) | d;
               6: m_rel = (m_rel & 'h00FF) | (d << 8);
               7: begin m_irq = (d >> 1) & 1; m_en = d & 1; end
`endif
               default: ;
            endcase
         end
      end else begin
`ifdef MAP_LATCH_IRQ_EN
         if (m_en != 0) begin
            if (m_cnt == 0) begin m_irq = 1; m_cnt = m_rel; end
            else m_cnt = m_cnt - 1;
         end
`endif
         if (!cpu_rw) begin
            if (a >= 'h8000) begin
               m_chr  = a % (1 << CHR_BW);
               m_mir  = (a >> 6) & 1;
               m_mode = (a >> 7) & 1;
               m_prg  = (a >> 8) % (1 << PRG_BW);
            end
            if (a >= 'h6000 && a < 'h8000 && m_lock == 0) begin
               m_outer = d % (1 << OUTER_BW);
               m_lock  = (d >> 7) & 1;
            end
`ifdef MAP_LATCH_IRQ_EN
            if (a == 'h5000) m_rel = (m_rel & 'hFF00) | d;
            if (a == 'h5001) m_rel = (m_rel & 'h00FF) | (d << 8);
            if (a == 'h5002) begin
               m_en = d & 1; m_irq = 0;
               if ((d & 1) != 0) m_cnt = m_rel;
            end
`endif
         end
      end
   endtask

   always @(negedge m2 or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_edge();
   end

   function automatic int exp_prg();
      int bank = m_prg;
      if (m_mode != 0) bank = (m_prg & ~1) | ((int'(cpu_addr) >> 14) & 1);
      return (m_outer << (PRG_BW + 14)) + (bank << 14) + (int'(cpu_addr) % 16384);
   endfunction

   function automatic int exp_chr();
      return (m_outer << (CHR_BW + 13)) + (m_chr << 13) + (int'(ppu_addr) % 8192);
   endfunction

   function automatic int exp_ciram();
      return (m_mir != 0) ? ((int'(ppu_addr) >> 11) & 1) : ((int'(ppu_addr) >> 10) & 1);
   endfunction

   function automatic int exp_ss(input int idx);
      case (idx)
         0: return (m_mode << 7) | (m_mir << 6) | m_chr;
         1: return m_prg;
         2: return (m_lock << 7) | m_outer;
`ifdef MAP_LATCH_IRQ_EN
         3: return m_cnt & 'hFF;
         4: return (m_cnt >> 8) & 'hFF;
         5: return m_rel & 'hFF;
         6: return (m_rel >> 8) & 'hFF;
         7: return (m_irq << 1) | m_en;
`endif
         default: return 'hFF;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("prg_addr", 32'(prg_addr), exp_prg());
      chk("chr_addr", 32'(chr_addr), exp_chr());
      chk("ciram_a10", 32'(ciram_a10), exp_ciram());
      chk("irq", 32'(irq), m_irq);
   endtask

   task automatic peek(input int idx);
      ss_addr = 8'(idx);
      #1;
      chk($sformatf("ss_rdat[%0d]", idx), 32'(ss_rdat), exp_ss(idx));
   endtask

   task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rw,
                      input logic sa, input logic swe, input logic [7:0] sidx);
      @(posedge m2);
      cpu_addr = a; cpu_dat = d; cpu_rw = rw;
      ss_act = sa; ss_we = swe; ss_addr = sidx;
      ppu_addr = 14'($urandom);
      @(negedge m2);
      #1;
      check_model();
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      bus(a, d, 1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic rd(input logic [15:0] a);
      bus(a, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic reset_pulse();
      @(posedge m2);
      #2 rst_n = 1'b0;
      ss_addr = 8'd2;
      #1;
      chk("rst_ss2", 32'(ss_rdat), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_prg", 32'(prg_addr), 32'(cpu_addr[13:0]));
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_addr = 16'h0000; cpu_dat = 8'h00; cpu_rw = 1'b1; ppu_addr = '0;
      ss_act = 1'b0; ss_we = 1'b0; ss_addr = 8'd0;
      @(posedge m2);
      #2 rst_n = 1'b1;

      // Reset state
      cpu_addr = 16'hC123; ppu_addr = 14'h1ABC;
      #1;
      chk("reset_prg", 32'(prg_addr), 32'h00123);
      chk("reset_chr", 32'(chr_addr), 32'h01ABC);
      chk("reset_irq", 32'(irq), 32'h0);
      for (int i = 0; i < 3; i++) begin
         ss_addr = 8'(i);
         #1;
         chk("reset_ss", 32'(ss_rdat), 32'h0);
      end

      // Latch write and mirroring
      wr(16'h8145, 8'hFF);
      peek(0);
      chk("latch_ss0", 32'(ss_rdat), 32'h45);
      rd(16'hC123);
      chk("latch_prg", 32'(prg_addr), 32'h04123);
      ppu_addr = 14'h0800;
      #1 chk("ciram_a11_hi", 32'(ciram_a10), 32'h1);
      ppu_addr = 14'h0400;
      #1 chk("ciram_a11_lo", 32'(ciram_a10), 32'h0);

      // 32 KB mode
      wr(16'h8380, 8'h00);
      rd(16'hC000);
      chk("mode32_hi", 32'(prg_addr[17:14]), 32'h3);
      rd(16'h8000);
      chk("mode32_lo", 32'(prg_addr[17:14]), 32'h2);

      // Outer bank lock
      wr(16'h6000, 8'h82);
      chk("outer_set", 32'(prg_addr[19:18]), 32'h2);
      wr(16'h6000, 8'h01);
      chk("outer_locked", 32'(prg_addr[19:18]), 32'h2);
      peek(2);
      chk("outer_ss2", 32'(ss_rdat), 32'h82);
      reset_pulse();
      rd(16'h8000);
      peek(2);

`ifdef MAP_LATCH_IRQ_EN
      // IRQ counter basic expiry
      wr(16'h5000, 8'h03);
      wr(16'h5001, 8'h00);
      wr(16'h5002, 8'h01);
      for (int e = 1; e <= 3; e++) begin
         rd(16'h0000);
         chk("irq_pending", 32'(irq), 32'h0);
      end
      rd(16'h0000);
      chk("irq_4th_edge", 32'(irq), 32'h1);
      peek(3);
      chk("irq_cnt_reload", 32'(ss_rdat), 32'h3);
      wr(16'h5002, 8'h00);
      chk("irq_ack", 32'(irq), 32'h0);
      for (int e = 0; e < 4; e++) begin
         rd(16'h0000);
         peek(3);
      end
      // Ack on the expiry edge, then reload write on the expiry edge
      wr(16'h5000, 8'h01);
      wr(16'h5002, 8'h01);
      rd(16'h0000);
      wr(16'h5002, 8'h01);
      chk("ack_wins", 32'(irq), 32'h0);
      peek(3);
      chk("ack_cnt", 32'(ss_rdat), 32'h1);
      rd(16'h0000);
      wr(16'h5000, 8'h05);
      chk("reload_race_irq", 32'(irq), 32'h1);
      peek(3);
      chk("reload_race_cnt", 32'(ss_rdat), 32'h1);
      peek(5);
      chk("reload_race_new", 32'(ss_rdat), 32'h5);
      wr(16'h5002, 8'h00);
`endif

      // Save-state overrides bus writes
      bus(16'h8000, 8'h40, 1'b0, 1'b1, 1'b1, 8'd0);
      peek(0);
      chk("ss_wr_idx0", 32'(ss_rdat), 32'h40);
      bus(16'h8FFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0);
      peek(0);
      chk("ss_bus_ignored", 32'(ss_rdat), 32'h40);
      peek(9);
      chk("ss_idx9", 32'(ss_rdat), 32'hFF);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [15:0] a;
         logic [7:0]  d;
         logic        rw, sa, swe;
         if ($urandom_range(0, 99) < 3) reset_pulse();
         d = 8'($urandom);
         case ($urandom_range(0, 3))
            0: a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            1: a = 16'h6000 | 16'($urandom_range(0, 16'h1FFF));
            2: a = 16'h5000 + 16'($urandom_range(0, 2));
            default: a = 16'($urandom);
         endcase
         if (a == 16'h5001 && $urandom_range(0, 3) != 0) d = 8'h00;
         rw  = ($urandom_range(0, 3) == 0);
         sa  = ($urandom_range(0, 9) == 0);
         swe = 1'($urandom);
         bus(a, d, rw, sa, swe, 8'($urandom_range(0, 9)));
         peek($urandom_range(0, 9));
      end

`ifndef MAP_LATCH_IRQ_EN
      // Without the counter, irq never asserts
      begin
         int seen = 0;
         wr(16'h5002, 8'h01);
         repeat (70000) begin
            @(negedge m2);
            #1;
            if (irq !== 1'b0) seen++;
         end
         chk("irq_off_long", 32'(seen), 32'h0);
         peek(3);
         peek(7);
         chk("irq_off_idx7", 32'(ss_rdat), 32'hFF);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
